tl_sensor: RTL and testbench

TL_SENSOR -- requirements
Module: tl_sensor

---
 rtl/tl_sensor.sv | 64 ++++++
 tb/tb_tl_sensor.sv | 99 +++++++++
 2 files changed

// File: rtl/tl_sensor.sv
// tl_sensor: per-street queue counters feeding the traffic-light controller's Ta/Tb inputs
module tl_street #(
  parameter int CW = 4,
  parameter int PASS_CYC = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          car,
  input  logic [1:0]    light,
  output logic [CW-1:0] cnt,
  output logic          ovf
);
  typedef enum logic [1:0] {EMPTY, WAIT, PASS} state_t;
  state_t st;
  logic [3:0] tmr;
  logic act, dep, full;
  logic [CW-1:0] nc;
  // the timer runs on the current light so a pass ends on the PASS_CYC-th green edge
  assign act = (st != EMPTY) && (light == 2'b00);
  assign dep = act && (tmr == 4'(PASS_CYC - 1));
  assign full = &cnt;
  assign nc = (car && !dep && !full) ? cnt + 1'b1 : (dep && !car) ? cnt - 1'b1 : cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
      tmr <= '0;
      st  <= EMPTY;
    end else begin
      cnt <= nc;
      ovf <= ovf | (car & full & ~dep);
      tmr <= (act && !dep) ? tmr + 4'd1 : 4'd0;
      st  <= (nc == '0) ? EMPTY : (light == 2'b00) ? PASS : WAIT;
    end
  end
endmodule

module tl_sensor #(
  parameter int CW = 4,
  parameter int PASS_CYC = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          car_a,
  input  logic          car_b,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  output logic          Ta,
  output logic          Tb,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b,
  output logic          ovf_a,
  output logic          ovf_b,
  output logic          viol
);
  tl_street #(.CW(CW), .PASS_CYC(PASS_CYC)) u_a (
    .clk(clk), .reset(reset), .car(car_a), .light(La), .cnt(cnt_a), .ovf(ovf_a));
  tl_street #(.CW(CW), .PASS_CYC(PASS_CYC)) u_b (
    .clk(clk), .reset(reset), .car(car_b), .light(Lb), .cnt(cnt_b), .ovf(ovf_b));
  assign Ta = cnt_a != '0;
  assign Tb = cnt_b != '0;
  always_ff @(posedge clk)
    viol <= reset ? 1'b0 : viol | (&La) | (&Lb) | (La != 2'b10 && Lb != 2'b10);
endmodule

// File: tb/tb_tl_sensor.sv
// tb_tl_sensor: directed vectors with hand-computed expectations for tl_sensor
module tb_tl_sensor;
  logic clk = 0, reset = 1, car_a = 0, car_b = 0;
  logic [1:0] La = 2'b10, Lb = 2'b10;
  logic Ta, Tb, ovf_a, ovf_b, viol;
  logic [3:0] cnt_a, cnt_b;
  int passed = 0, total = 0;

  tl_sensor #(.CW(4), .PASS_CYC(3)) dut (
    .clk(clk), .reset(reset), .car_a(car_a), .car_b(car_b), .La(La), .Lb(Lb),
    .Ta(Ta), .Tb(Tb), .cnt_a(cnt_a), .cnt_b(cnt_b), .ovf_a(ovf_a), .ovf_b(ovf_b), .viol(viol));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick();
    chk("rst_cnt_a", cnt_a, 0); chk("rst_cnt_b", cnt_b, 0);
    chk("rst_Ta", Ta, 0); chk("rst_Tb", Tb, 0);
    chk("rst_ovf_a", ovf_a, 0); chk("rst_ovf_b", ovf_b, 0); chk("rst_viol", viol, 0);
    reset = 0;
    // single car arrives on red, then departs after three green edges
    car_a = 1; tick(); car_a = 0;
    chk("arr_cnt_a", cnt_a, 1); chk("arr_Ta", Ta, 1);
    La = 2'b00;
    tick(); chk("g1_cnt_a", cnt_a, 1);
    tick(); chk("g2_cnt_a", cnt_a, 1);
    tick(); chk("g3_cnt_a", cnt_a, 0); chk("g3_Ta", Ta, 0);
    // two queued cars; arrival coincides with the second departure
    La = 2'b10;
    car_a = 1; tick(2); car_a = 0;
    chk("q2_cnt_a", cnt_a, 2);
    La = 2'b00;
    tick(2); chk("q2_hold", cnt_a, 2);
    tick(); chk("q2_dep", cnt_a, 1);
    tick(2); car_a = 1; tick(); car_a = 0;
    chk("arr_dep_same", cnt_a, 1);
    // green interrupted by yellow loses the partial pass
    tick(2); La = 2'b01; tick();
    chk("yel_cnt_a", cnt_a, 1);
    La = 2'b00;
    tick(2); chk("regreen_hold", cnt_a, 1);
    tick(); chk("regreen_dep", cnt_a, 0);
    chk("no_viol", viol, 0);
    // street B overflow
    La = 2'b10;
    car_b = 1; tick(15);
    chk("b15_cnt", cnt_b, 15); chk("b15_ovf", ovf_b, 0);
    tick(); car_b = 0;
    chk("b16_cnt", cnt_b, 15); chk("b16_ovf", ovf_b, 1);
    chk("b16_Tb", Tb, 1); chk("indep_ovf_a", ovf_a, 0); chk("indep_cnt_a", cnt_a, 0);
    reset = 1; tick(); reset = 0;
    chk("rst2_cnt_b", cnt_b, 0); chk("rst2_ovf_b", ovf_b, 0); chk("rst2_Tb", Tb, 0);
    // full queue with arrival and departure on the same edge
    car_b = 1; tick(15); car_b = 0;
    Lb = 2'b00;
    tick(2); car_b = 1; tick(); car_b = 0;
    chk("full_ad_cnt", cnt_b, 15); chk("full_ad_ovf", ovf_b, 0);
    // reset mid-pass discards queue and same-cycle arrival
    Lb = 2'b10; reset = 1; tick(); reset = 0;
    car_b = 1; tick(3); car_b = 0;
    chk("b3_cnt", cnt_b, 3);
    Lb = 2'b00; tick(2);
    reset = 1; car_b = 1; tick(); reset = 0; car_b = 0;
    chk("midrst_cnt_b", cnt_b, 0); chk("midrst_Tb", Tb, 0);
    tick(2); chk("midrst_after", cnt_b, 0);
    // street A overflow independent of B
    Lb = 2'b10;
    car_a = 1; tick(16); car_a = 0;
    chk("a16_ovf_a", ovf_a, 1); chk("a16_ovf_b", ovf_b, 0);
    // violations
    reset = 1; tick(); reset = 0;
    La = 2'b00; Lb = 2'b01; tick();
    chk("viol_both", viol, 1);
    Lb = 2'b10; tick();
    chk("viol_sticky", viol, 1);
    La = 2'b11; reset = 1; tick();
    chk("viol_rst_prio", viol, 0);
    reset = 0; tick();
    chk("viol_11", viol, 1);
    La = 2'b10; reset = 1; tick(); reset = 0;
    Lb = 2'b11; tick();
    chk("viol_b11", viol, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
